// File: rtl/lapido_pkg.sv
// Lapido shared types for the memory stage.
// State encoding, datapath widths, default timeout.
package lapido_pkg;
  localparam int DATA_W      = 32;
  localparam int REG_W       = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; i_bubble forces o_rw=0.
// Ports: clock, reset, i_bubble, i_{alu,rdata,m2r,rd,rw}, o_*.
module mem_wb_reg
  import lapido_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_m2r,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_rw,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_m2r,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_rw
);
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rdata;
  logic              r_m2r;
  logic [REG_W-1:0]  r_rd;
  logic              r_rw;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alu   <= '0;
      r_rdata <= '0;
      r_m2r   <= 1'b0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
    end else begin
      r_alu   <= i_alu;
      r_rdata <= i_rdata;
      r_m2r   <= i_m2r;
      r_rd    <= i_rd;
      r_rw    <= i_rw & ~i_bubble;
    end
  end

  assign o_alu   = r_alu;
  assign o_rdata = r_rdata;
  assign o_m2r   = r_m2r;
  assign o_rd    = r_rd;
  assign o_rw    = r_rw;
endmodule

// File: rtl/mem_stage.sv
// Lapido memory stage: req/ready dmem handshake, upstream stall, MEM/WB.
// Ports: clock/reset, EX/MEM *_in, dmem_*, MEM/WB outs, stall, memError.
// Optional MEM_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES, set memError.
module mem_stage
  import lapido_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     ALUResult_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  input  logic                  memToReg_in,
  input  logic [DATA_W-1:0]     registerFileDataB_in,
  input  logic [REG_W-1:0]      registerFileWrite_in,
  input  logic                  regWrite_in,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic [DATA_W-1:0]     memReadData,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  memToReg,
  output logic [REG_W-1:0]      registerFileWrite,
  output logic                  regWrite,
  output logic                  memError
);
  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [REG_W-1:0]  r_rd;
  logic              r_rw;
  logic              r_m2r;

  logic              w_acc;
  logic              w_tmo;
  logic              w_stall;
  logic              w_bubble;
  logic              w_capture;
  logic [DATA_W-1:0] w_wb_alu;
  logic [DATA_W-1:0] w_wb_rdata;
  logic              w_wb_m2r;
  logic [REG_W-1:0]  w_wb_rd;
  logic              w_wb_rw;

  assign w_acc = memRead_in | memWrite_in;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alu   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
    end else if (w_capture) begin
      r_alu   <= ALUResult_in;
      r_wdata <= registerFileDataB_in;
      r_we    <= memWrite_in;
      r_rd    <= registerFileWrite_in;
      r_rw    <= regWrite_in;
      r_m2r   <= memToReg_in;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_bubble   = 1'b1;
    w_capture  = 1'b0;
    w_wb_alu   = ALUResult_in;
    w_wb_m2r   = memToReg_in;
    w_wb_rd    = registerFileWrite_in;
    w_wb_rw    = regWrite_in;
    w_wb_rdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_stall   = 1'b1;
          w_capture = 1'b1;
          w_next    = S_WAIT;
        end else begin
          w_bubble = 1'b0;
        end
      end
      S_WAIT: begin
        w_wb_alu = r_alu;
        w_wb_m2r = r_m2r;
        w_wb_rd  = r_rd;
        w_wb_rw  = r_rw;
        // ready beats a coincident timeout
        if (dmem_ready) begin
          w_bubble   = 1'b0;
          w_wb_rdata = r_we ? '0 : dmem_rdata;
          w_next     = S_IDLE;
        end else if (w_tmo) begin
          w_next = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_capture)
        r_cnt <= '0;
      else if (r_state == S_WAIT && !dmem_ready)
        r_cnt <= r_cnt + 1'b1;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end

  // r_cnt counts earlier idle WAIT cycles; this one is the last allowed
  assign w_tmo = (r_state == S_WAIT) && !dmem_ready &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign memError = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES < 1);
  assign w_tmo    = 1'b0;
  assign memError = 1'b0;
`endif

  assign stall      = w_stall & ~reset;
  assign dmem_req   = (r_state == S_WAIT);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_alu[ADDR_WIDTH-1:0];
  assign dmem_wdata = r_wdata;

  mem_wb_reg u_mem_wb (
    .clock   (clock),
    .reset   (reset),
    .i_bubble(w_bubble),
    .i_alu   (w_wb_alu),
    .i_rdata (w_wb_rdata),
    .i_m2r   (w_wb_m2r),
    .i_rd    (w_wb_rd),
    .i_rw    (w_wb_rw),
    .o_alu   (ALUResult),
    .o_rdata (memReadData),
    .o_m2r   (memToReg),
    .o_rd    (registerFileWrite),
    .o_rw    (regWrite)
  );
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with an instruction-level model.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
  logic        clock;
  logic        reset;
  logic [31:0] ALUResult_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic        memToReg_in;
  logic [31:0] registerFileDataB_in;
  logic [3:0]  registerFileWrite_in;
  logic        regWrite_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] memReadData;
  logic [31:0] ALUResult;
  logic        memToReg;
  logic [3:0]  registerFileWrite;
  logic        regWrite;
  logic        memError;

  mem_stage #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .ALUResult_in        (ALUResult_in),
    .memRead_in          (memRead_in),
    .memWrite_in         (memWrite_in),
    .memToReg_in         (memToReg_in),
    .registerFileDataB_in(registerFileDataB_in),
    .registerFileWrite_in(registerFileWrite_in),
    .regWrite_in         (regWrite_in),
    .stall               (stall),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ready          (dmem_ready),
    .memReadData         (memReadData),
    .ALUResult           (ALUResult),
    .memToReg            (memToReg),
    .registerFileWrite   (registerFileWrite),
    .regWrite            (regWrite),
    .memError            (memError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stall_cyc = 0;
  logic chk_en = 1'b0;

  // expectations for the current cycle
  logic        e_stall, e_req, e_we, e_err;
  logic [15:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_rw, e_m2r;
  logic [31:0] e_alu, e_rdata;
  logic [3:0]  e_rd;
  // write-back owed by the last retired instruction
  logic        p_rw, p_m2r;
  logic [31:0] p_alu, p_rdata;
  logic [3:0]  p_rd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", 32'(dmem_addr), 32'(e_addr));
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("regWrite", 32'(regWrite), 32'(e_rw));
      if (e_rw) begin
        chk("ALUResult", ALUResult, e_alu);
        chk("memToReg", 32'(memToReg), 32'(e_m2r));
        chk("registerFileWrite", 32'(registerFileWrite), 32'(e_rd));
        chk("memReadData", memReadData, e_rdata);
      end
      chk("memError", 32'(memError), 32'(e_err));
    end
  end

  task automatic load_wb;
    e_rw    = p_rw;
    e_alu   = p_alu;
    e_m2r   = p_m2r;
    e_rd    = p_rd;
    e_rdata = p_rdata;
    p_rw    = 1'b0;
  endtask

  task automatic tick;
    #1;
    if (stall) n_stall_cyc++;
    @(posedge clock);
    #2;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 store with memRead_in also set
  task automatic do_instr(input int kind, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [3:0] rd,
                          input logic rw, input logic m2r, input int lat,
                          input logic [31:0] md);
    ALUResult_in         = alu;
    registerFileDataB_in = wd;
    registerFileWrite_in = rd;
    regWrite_in          = rw;
    memToReg_in          = m2r;
    memRead_in           = (kind == 1) || (kind == 3);
    memWrite_in          = (kind >= 2);
    dmem_ready           = 1'($urandom_range(0, 1));
    dmem_rdata           = $urandom;
    e_req                = 1'b0;
    e_stall              = (kind != 0);
    load_wb();
    tick();
    if (kind != 0) begin
      for (int k = 1; k <= lat + 1; k++) begin
        e_req      = 1'b1;
        e_we       = (kind >= 2);
        e_addr     = alu[15:0];
        e_wdata    = wd;
        dmem_ready = (k == lat + 1);
        dmem_rdata = (k == lat + 1) ? md : $urandom;
        e_stall    = (k <= lat);
        load_wb();
        tick();
      end
    end
    dmem_ready = 1'b0;
    e_req      = 1'b0;
    p_rw       = rw;
    p_alu      = alu;
    p_m2r      = m2r;
    p_rd       = rd;
    p_rdata    = (kind == 1) ? md : 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    ALUResult_in = '0; memRead_in = 0; memWrite_in = 0;
    memToReg_in = 0; registerFileDataB_in = '0;
    registerFileWrite_in = '0; regWrite_in = 0;
    dmem_rdata = '0; dmem_ready = 0;
    e_stall = 0; e_req = 0; e_we = 0; e_err = 0;
    e_addr = '0; e_wdata = '0;
    e_rw = 0; e_m2r = 0; e_alu = '0; e_rdata = '0; e_rd = '0;
    p_rw = 0; p_m2r = 0; p_alu = '0; p_rdata = '0; p_rd = '0;
    @(posedge clock);
    #2;
    tick();
    chk_en = 1'b1;
    chk("rst_ALUResult", ALUResult, 32'h0);
    chk("rst_memReadData", memReadData, 32'h0);
    chk("rst_regWrite", 32'(regWrite), 32'h0);
    chk("rst_dmem_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;

    // ALU pass-through
    n_stall_cyc = 0;
    do_instr(0, 32'h1234, 32'h0, 4'd5, 1'b1, 1'b0, 0, 32'h0);
    chk("alu_ALUResult", ALUResult, 32'h1234);
    chk("alu_regWrite", 32'(regWrite), 32'h1);
    chk("alu_rd", 32'(registerFileWrite), 32'h5);
    chk("alu_stall_cycles", 32'(n_stall_cyc), 32'h0);

    // load with ready three cycles after req
    n_stall_cyc = 0;
    do_instr(1, 32'h0010, 32'h0, 4'd7, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    chk("ld_stall_cycles", 32'(n_stall_cyc), 32'h4);
    chk("ld_memReadData", memReadData, 32'hDEADBEEF);
    chk("ld_memToReg", 32'(memToReg), 32'h1);
    chk("ld_regWrite", 32'(regWrite), 32'h1);

    // store with both request bits, ready immediately
    do_instr(3, 32'h0020, 32'hCAFEF00D, 4'd2, 1'b1, 1'b0, 0, 32'h0);
    chk("st_memReadData", memReadData, 32'h0);
    chk("st_regWrite", 32'(regWrite), 32'h1);

    // back-to-back loads
    do_instr(1, 32'h0100, 32'h0, 4'd1, 1'b1, 1'b1, 0, 32'h11112222);
    do_instr(1, 32'h0104, 32'h0, 4'd2, 1'b1, 1'b1, 1, 32'h33334444);
    do_instr(0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 0, 32'h0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      do_instr(int'($urandom_range(0, 3)), $urandom, $urandom,
               4'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), $urandom);
    end

    // reset while an access is outstanding, ready on the reset edge
    ALUResult_in = 32'h40; registerFileDataB_in = 32'h0;
    memRead_in = 1; memWrite_in = 0;
    regWrite_in = 1; registerFileWrite_in = 4'd3; memToReg_in = 1;
    dmem_ready = 0;
    e_stall = 1; e_req = 0;
    load_wb();
    tick();
    e_req = 1; e_we = 0; e_addr = 16'h40; e_wdata = 32'h0; e_stall = 1;
    load_wb();
    tick();
    reset = 1; dmem_ready = 1; dmem_rdata = 32'h5555AAAA;
    e_stall = 0; e_req = 1;
    load_wb();
    tick();
    reset = 0; dmem_ready = 0;
    memRead_in = 0; memWrite_in = 0; regWrite_in = 0;
    e_stall = 0; e_req = 0; e_err = 0;
    p_rw = 0;
    load_wb();
    #1;
    chk("rrst_dmem_req", 32'(dmem_req), 32'h0);
    chk("rrst_stall", 32'(stall), 32'h0);
    chk("rrst_regWrite", 32'(regWrite), 32'h0);
    tick();
    do_instr(0, 32'h77, 32'h0, 4'd9, 1'b1, 1'b0, 0, 32'h0);
    chk("rrst_alu_after", ALUResult, 32'h77);

`ifdef MEM_TIMEOUT_EN
    // load that never completes: aborted after 4 WAIT cycles
    ALUResult_in = 32'h80; memRead_in = 1; memWrite_in = 0;
    regWrite_in = 1; registerFileWrite_in = 4'd4; memToReg_in = 1;
    dmem_ready = 0;
    e_stall = 1; e_req = 0;
    load_wb();
    tick();
    for (int k = 1; k <= 4; k++) begin
      e_req = 1; e_we = 0; e_addr = 16'h80; e_wdata = registerFileDataB_in;
      e_stall = (k < 4);
      load_wb();
      tick();
    end
    e_req = 0; e_err = 1;
    p_rw = 0;
    do_instr(0, 32'hABCD, 32'h0, 4'd6, 1'b1, 1'b0, 0, 32'h0);
    chk("tmo_memError", 32'(memError), 32'h1);
    chk("tmo_alu_after", ALUResult, 32'hABCD);
    chk("tmo_regWrite_after", 32'(regWrite), 32'h1);
`else
    chk("no_tmo_memError", 32'(memError), 32'h0);
`endif
    do_instr(0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 0, 32'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
